// File: rtl/inst_package.sv
// Shared FPU result-path definitions.
// Holds the standard FPU result latencies and the writeback slot record that the
// writeback scheduler keeps per reserved cycle.
package inst_package;

  localparam int unsigned FPU_LAT_ONE = 1;  // ftoi / itof
  localparam int unsigned FPU_LAT_TWO = 2;  // fadd / fsub / fmul / fsqrt
  localparam int unsigned FPU_LAT_DIV = 4;  // fdiv

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } wb_slot_t;

endpackage

// File: rtl/wb_busy_table.sv
// Pending-destination table for the FPU writeback scheduler.
// One bit per GPR, set when a result is reserved and cleared when it retires.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   set_en, set_rd    mark set_rd pending (ignored for r0)
//   clr_en, clr_rd    mark clr_rd no longer pending; wins over a same-edge set
//   rd_a, a_busy      combinational read port A
//   rd_b, b_busy      combinational read port B
//   busy_vec          full vector, used by the grant logic for the WAW check
module wb_busy_table (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [4:0]  set_rd,
  input  logic        clr_en,
  input  logic [4:0]  clr_rd,
  input  logic [4:0]  rd_a,
  output logic        a_busy,
  input  logic [4:0]  rd_b,
  output logic        b_busy,
  output logic [31:0] busy_vec
);

  logic [31:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (set_en && (set_rd != 5'd0)) busy_d[set_rd] = 1'b1;
    if (clr_en) busy_d[clr_rd] = 1'b0;
    busy_d[0] = 1'b0;  // r0 is never a real destination
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign a_busy   = busy_q[rd_a];
  assign b_busy   = busy_q[rd_b];
  assign busy_vec = busy_q;

endmodule

// File: rtl/wb_slot_scheduler.sv
// Per-lane FPU writeback-port scheduler.
// Reserves the single GPR write slot each multi-cycle FPU op will use, so two
// results never land in the same writeback cycle, and tracks pending
// destinations for the decode RAW/WAW interlock.
// Optional feature: define WB_SCHED_STATS_EN to add saturating grant_cnt and
// conflict_cnt outputs.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   interlock              pipeline freeze: no shift, no accept, busy frozen
//   req_valid/lat/rd       op presented for issue (lat 1..MAX_LAT)
//   req_ready              combinational grant, independent of req_valid
//   query_rs/query_rt      hazard query registers
//   rs_busy/rt_busy        combinational pending flags for the queries
//   wb_valid/wb_rd         registered retirement of slot 0
//   pending_cnt            registered count of occupied slots
module wb_slot_scheduler
  import inst_package::*;
#(
  parameter int unsigned MAX_LAT = FPU_LAT_DIV,
  parameter int unsigned LAT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             interlock,
  input  logic             req_valid,
  input  logic [LAT_W-1:0] req_lat,
  input  logic [4:0]       req_rd,
  output logic             req_ready,
  input  logic [4:0]       query_rs,
  input  logic [4:0]       query_rt,
  output logic             rs_busy,
  output logic             rt_busy,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [LAT_W-1:0] pending_cnt
`ifdef WB_SCHED_STATS_EN
  ,
  output logic [31:0]      grant_cnt,
  output logic [31:0]      conflict_cnt
`endif
);

  wb_slot_t slot_q  [MAX_LAT];
  wb_slot_t slot_d  [MAX_LAT];
  wb_slot_t shifted [MAX_LAT];

  logic             advance;
  logic             accept;
  logic             lat_ok;
  logic             slot_free;
  logic             waw_ok;
  logic [31:0]      busy_vec;
  logic [LAT_W-1:0] cnt_d, cnt_q;

  assign advance = ~interlock;

  // Slot contents after one advance, before any insert.
  always_comb begin
    shifted[MAX_LAT-1] = '0;
    for (int i = 0; i < int'(MAX_LAT) - 1; i++) begin
      shifted[i] = slot_q[i+1];
    end
  end

  // The target index must still be empty after the shift, i.e. slot[req_lat]
  // must not be about to move into it.
  always_comb begin
    slot_free = 1'b0;
    for (int i = 0; i < int'(MAX_LAT); i++) begin
      if (req_lat == LAT_W'(i + 1)) slot_free = ~shifted[i].valid;
    end
  end

  assign lat_ok    = (req_lat != '0) && (32'(req_lat) <= MAX_LAT);
  assign waw_ok    = (req_rd == 5'd0) || !busy_vec[req_rd];
  assign req_ready = advance && lat_ok && slot_free && waw_ok;
  assign accept    = req_valid && req_ready;

  always_comb begin
    for (int i = 0; i < int'(MAX_LAT); i++) begin
      slot_d[i] = slot_q[i];
    end
    if (advance) begin
      for (int i = 0; i < int'(MAX_LAT); i++) begin
        slot_d[i] = shifted[i];
        if (accept && (req_lat == LAT_W'(i + 1))) begin
          slot_d[i].valid = 1'b1;
          slot_d[i].rd    = req_rd;
        end
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < int'(MAX_LAT); i++) begin
      cnt_d = cnt_d + LAT_W'(slot_d[i].valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_LAT); i++) begin
        slot_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(MAX_LAT); i++) begin
        slot_q[i] <= slot_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

  assign wb_valid    = slot_q[0].valid;
  assign wb_rd       = slot_q[0].rd;
  assign pending_cnt = cnt_q;

  // The destination stays busy through its own writeback cycle and clears on
  // the advance edge that retires it.
  wb_busy_table u_busy (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept),
    .set_rd   (req_rd),
    .clr_en   (advance && slot_q[0].valid),
    .clr_rd   (slot_q[0].rd),
    .rd_a     (query_rs),
    .a_busy   (rs_busy),
    .rd_b     (query_rt),
    .b_busy   (rt_busy),
    .busy_vec (busy_vec)
  );

`ifdef WB_SCHED_STATS_EN
  logic [31:0] grant_q, conflict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      conflict_q <= '0;
    end else begin
      if (accept && (grant_q != '1)) grant_q <= grant_q + 32'd1;
      if (advance && req_valid && !req_ready && (conflict_q != '1)) begin
        conflict_q <= conflict_q + 32'd1;
      end
    end
  end

  assign grant_cnt    = grant_q;
  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: doc/wb_slot_scheduler.md
Name: wb_slot_scheduler

Overview:
- Per-lane writeback-port scheduler for the FPU result path. Instantiate once for the upper lane and once for the lower lane.
- At issue time it reserves the single GPR write slot that each multi-cycle FPU op will use: 1 clk (ftoi/itof), 2 clk (fadd/fsub/fmul/fsqrt), 4 clk (fdiv).
- Two results therefore never collide in the same writeback cycle and are never silently dropped by the writeback priority mux.
- Also tracks pending destination registers for RAW/WAW interlock in decode.

Parameters:
- MAX_LAT, 4, longest supported result latency in clocks (number of slots).
- LAT_W, 3, width of the latency field; must hold MAX_LAT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- interlock  in  1  pipeline freeze (same signal that freezes writeback).
- req_valid  in  1  decode presents an FPU op for issue.
- req_lat  in  LAT_W  result latency of the op, 1..MAX_LAT.
- req_rd  in  5  destination GPR.
- req_ready  out  1  grant. Combinational; the op issues on the edge where req_valid && req_ready.
- query_rs  in  5  source register A for hazard check.
- query_rt  in  5  source register B for hazard check.
- rs_busy  out  1  query_rs has a pending result. Combinational.
- rt_busy  out  1  query_rt has a pending result. Combinational.
- wb_valid  out  1  scheduled result retires this cycle. Registered.
- wb_rd  out  5  destination of the retiring result. Registered.
- pending_cnt  out  LAT_W  number of occupied slots. Registered.

Behaviour:
- State:
  - slot[0..MAX_LAT-1], each {valid, rd}. slot[0] drives wb_valid/wb_rd directly.
  - busy[31:0] bit vector.
- Reset (rst=1 at an edge), including mid-operation:
  - All slot.valid = 0, busy = 0, pending_cnt = 0, wb_valid = 0, wb_rd = 0.
  - In-flight reservations are discarded.
- Advance (edge with ~interlock):
  - slot[i] <= slot[i+1] for i < MAX_LAT-1.
  - slot[MAX_LAT-1] <= empty.
  - If the request is accepted, slot[req_lat-1] <= {1, req_rd}. Insert overrides the shift into that index; no conflict can exist because of the grant rule.
- Latency rule: a request accepted in cycle t gives wb_valid=1, wb_rd=req_rd in cycle t+req_lat.
- Grant rule. req_ready = 1 only when all of the following hold:
  - ~interlock;
  - 1 <= req_lat <= MAX_LAT;
  - req_lat == MAX_LAT, or slot[req_lat].valid == 0 (that entry would shift into the target index);
  - req_rd == 0, or busy[req_rd] == 0 (WAW block).
- req_ready is independent of req_valid.
- busy[] update:
  - Set busy[req_rd] on accept when req_rd != 0.
  - Clear busy[slot[0].rd] on each advance edge where slot[0].valid.
  - A same-edge set and clear on the same register cannot occur, because WAW is blocked while busy. Clear takes precedence if it ever happens.
- Hazard queries:
  - rs_busy = busy[query_rs]; rt_busy = busy[query_rt].
  - r0 always reads not busy.
  - A register stays busy during its own wb cycle, because the GPR write lands at the end of that cycle.
- Interlock=1:
  - No shift, no accept, busy frozen.
  - wb_valid/wb_rd hold their values; writeback also ignores them during interlock.
- pending_cnt equals the popcount of slot.valid after each edge.

Optional Feature:
- Macro: WB_SCHED_STATS_EN.
- When defined:
  - Adds outputs grant_cnt[31:0] and conflict_cnt[31:0], both saturating and cleared by rst.
  - grant_cnt increments on each accept.
  - conflict_cnt increments on each ~interlock cycle where req_valid=1 and req_ready=0.
- When undefined: the ports and counters are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package (inst_package) gets:
  - constants FPU_LAT_ONE=1, FPU_LAT_TWO=2, FPU_LAT_DIV=4;
  - typedef wb_slot_t {logic valid; logic [4:0] rd;}.
- One sub-module: wb_busy_table. It holds the 32-bit busy vector with set/clear ports and two combinational read ports.
- The slot shift register stays in the top module.

Test Plan:
- Single fdiv:
  - Stimulus: reset; accept lat=4, rd=7 at cycle 10.
  - Response: wb_valid=1, wb_rd=7 only in cycle 14; rs_busy(7)=1 in cycles 11-14 and 0 in cycle 15.
- Slot collision:
  - Stimulus: accept lat=4, rd=3 at cycle 0; request lat=2, rd=5 at cycle 2.
  - Response: req_ready=0 at cycle 2. The same request at cycle 3 is granted and retires at cycle 5, with rd=3 retiring at cycle 4.
- Back-to-back mixed latencies:
  - Stimulus: lat=1 rd=1 at t=0, lat=2 rd=2 at t=1, lat=1 rd=4 at t=2.
  - Response: retire order rd 1, 2, 4 at cycles 1, 3, 3? Not allowed: rd=4 conflicts with rd=2 at cycle 3, so req_ready=0 at t=2. Retire order is rd 1 at cycle 1 and rd 2 at cycle 3.
- WAW and r0:
  - Stimulus: rd=9 pending; new request rd=9.
  - Response: req_ready=0. Two requests to rd=0 at different latencies are both granted, and busy(0) is always 0.
- Interlock freeze:
  - Stimulus: lat=2 accepted at cycle 0; interlock high in cycles 1-3.
  - Response: wb_valid rises in cycle 5; req_ready=0 throughout cycles 1-3.
- Reset mid-flight:
  - Stimulus: three slots occupied; rst pulse for one cycle.
  - Response: next cycle wb_valid=0, pending_cnt=0, all busy=0, and no later retirements.
